// File: rtl/sram_arb_pkg.sv
// Shared types for the VGA/host SRAM arbiter: bus widths, access state and host command.
package sram_arb_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        DISP,
        HRD,
        HWR
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/sram_arb_cmd_fifo.sv
// Host command FIFO: power-of-2 depth, async reset, show-ahead head entry.
module sram_arb_cmd_fifo
    import sram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  cmd_t i_cmd,
    input  logic i_pop,
    output cmd_t o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    cmd_t             r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit separates full from empty when the indices coincide.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_cmd;
    end

endmodule

// File: rtl/vga_sram_arbiter.sv
// Display-priority SRAM arbiter with a queued host port.
// Define SRAM_ARB_BLANK_WRITE_EN to restrict host accesses to blanking intervals.
module vga_sram_arbiter #(
    parameter int unsigned ADDR_W     = sram_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W     = sram_arb_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned H_DISPLAY  = 800,
    parameter int unsigned V_DISPLAY  = 600
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hc,
    input  logic [9:0]        vc,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    import sram_arb_pkg::*;

    state_t            r_state;
    state_t            w_next_state;
    cmd_t              w_cmd;
    cmd_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_issue_ok;
    logic [ADDR_W-1:0] w_next_addr;

`ifdef SRAM_ARB_BLANK_WRITE_EN
    localparam logic [10:0] H_LIM = 11'(H_DISPLAY);
    localparam logic [9:0]  V_LIM = 10'(V_DISPLAY);
    assign w_issue_ok = (hc >= H_LIM) || (vc >= V_LIM);
`else
    logic w_unused_counts;
    assign w_unused_counts = ^{hc, vc};
    assign w_issue_ok      = 1'b1;
`endif

    assign w_cmd      = '{we: host_we, addr: host_addr, data: host_wdata};
    assign host_ready = !w_full;

    sram_arb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (host_valid && !w_full),
        .i_cmd   (w_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next_state = IDLE;
        w_pop        = 1'b0;
        w_next_addr  = sram_addr;
        if (disp_req) begin
            w_next_state = DISP;
            w_next_addr  = disp_addr;
        end else if (!w_empty && w_issue_ok) begin
            w_pop        = 1'b1;
            w_next_state = w_head.we ? HWR : HRD;
            w_next_addr  = w_head.addr;
        end
    end

    // Strobes are registered together with the state so each access occupies exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            sram_addr  <= w_next_addr;
            sram_oe_n  <= !(w_next_state inside {DISP, HRD});
            sram_we_n  <= (w_next_state != HWR);
            sram_dq_oe <= (w_next_state == HWR);
            if (w_next_state == HWR) sram_dq_out <= w_head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_rdata  <= '0;
            disp_rvalid <= 1'b0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            disp_rvalid <= (r_state == DISP);
            host_rvalid <= (r_state == HRD);
            if (r_state == DISP) disp_rdata <= sram_dq_in;
            if (r_state == HRD)  host_rdata <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Self-checking bench for vga_sram_arbiter: SRAM device model plus a queue-based reference model.
module tb_vga_sram_arbiter;

    localparam int FD     = 4;
    localparam int K_IDLE = 0;
    localparam int K_DISP = 1;
    localparam int K_HRD  = 2;
    localparam int K_HWR  = 3;

    logic        clk;
    logic        reset;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        disp_req;
    logic [19:0] disp_addr;
    logic [15:0] disp_rdata;
    logic        disp_rvalid;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [19:0] host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        host_rvalid;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;

    vga_sram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .hc          (hc),
        .vc          (vc),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rdata  (disp_rdata),
        .disp_rvalid (disp_rvalid),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    always #5 clk = ~clk;

    int checks;
    int failures;

    typedef struct {
        bit        we;
        bit [19:0] addr;
        bit [15:0] data;
    } mcmd_t;

    // SRAM device contents (driven by DUT pins) and the model's own view of memory.
    logic [15:0] dev_mem [int unsigned];
    logic [15:0] sh_mem  [int unsigned];
    mcmd_t       q [$];

    int          m_kind;
    logic [19:0] m_addr;
    logic [15:0] m_wdata;
    bit          m_drv;
    bit          m_hrv;
    logic [15:0] m_drdata;
    logic [15:0] m_hrdata;

    function automatic logic [15:0] dflt(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], 12'h5A3};
    endfunction

    function automatic logic [15:0] dev_rd(input logic [19:0] a);
        if (dev_mem.exists(int'(a))) return dev_mem[int'(a)];
        return dflt(a);
    endfunction

    function automatic logic [15:0] sh_rd(input logic [19:0] a);
        if (sh_mem.exists(int'(a))) return sh_mem[int'(a)];
        return dflt(a);
    endfunction

    function automatic bit blank_ok();
`ifdef SRAM_ARB_BLANK_WRITE_EN
        return (hc >= 11'd800) || (vc >= 10'd600);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_kind   = K_IDLE;
        m_addr   = '0;
        m_wdata  = '0;
        m_drv    = 0;
        m_hrv    = 0;
        m_drdata = '0;
        m_hrdata = '0;
    endtask

    // Called at a negedge: compare, run the SRAM device, drive inputs, advance model to the next cycle.
    task automatic step(input bit dreq, input logic [19:0] daddr, input bit hv, input bit hwe,
                        input logic [19:0] haddr, input logic [15:0] hwd);
        bit    push;
        mcmd_t c;
        check("oe_n", 32'(sram_oe_n), 32'(!(m_kind == K_DISP || m_kind == K_HRD)));
        check("we_n", 32'(sram_we_n), 32'(m_kind != K_HWR));
        check("dq_oe", 32'(sram_dq_oe), 32'(m_kind == K_HWR));
        if (m_kind != K_IDLE) check("sram_addr", 32'(sram_addr), 32'(m_addr));
        if (m_kind == K_HWR) check("dq_out", 32'(sram_dq_out), 32'(m_wdata));
        check("disp_rvalid", 32'(disp_rvalid), 32'(m_drv));
        check("disp_rdata", 32'(disp_rdata), 32'(m_drdata));
        check("host_rvalid", 32'(host_rvalid), 32'(m_hrv));
        check("host_rdata", 32'(host_rdata), 32'(m_hrdata));
        check("host_ready", 32'(host_ready), 32'(q.size() < FD));

        sram_dq_in = !sram_oe_n ? dev_rd(sram_addr) : 16'h0BAD;
        if (!sram_we_n) dev_mem[int'(sram_addr)] = sram_dq_out;

        m_drv = 0;
        m_hrv = 0;
        case (m_kind)
            K_DISP: begin m_drv = 1; m_drdata = sh_rd(m_addr); end
            K_HRD:  begin m_hrv = 1; m_hrdata = sh_rd(m_addr); end
            K_HWR:  sh_mem[int'(m_addr)] = m_wdata;
            default: ;
        endcase

        disp_req   = dreq;
        disp_addr  = daddr;
        host_valid = hv;
        host_we    = hwe;
        host_addr  = haddr;
        host_wdata = hwd;

        push = hv && (q.size() < FD);
        if (dreq) begin
            m_kind = K_DISP;
            m_addr = daddr;
        end else if (q.size() > 0 && blank_ok()) begin
            c       = q.pop_front();
            m_kind  = c.we ? K_HWR : K_HRD;
            m_addr  = c.addr;
            m_wdata = c.data;
        end else begin
            m_kind = K_IDLE;
        end
        if (push) q.push_back('{hwe, haddr, hwd});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_host_ready", 32'(host_ready), 32'd1);
        model_clear();
        disp_req   = 0;
        host_valid = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit [5:0] pat;
        int       cnt;
        bit       got;
        clk        = 0;
        reset      = 1;
        hc         = 11'd800;
        vc         = 10'd0;
        disp_req   = 0;
        disp_addr  = '0;
        host_valid = 0;
        host_we    = 0;
        host_addr  = '0;
        host_wdata = '0;
        sram_dq_in = '0;
        checks     = 0;
        failures   = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        check("init_we_n", 32'(sram_we_n), 32'd1);
        check("init_oe_n", 32'(sram_oe_n), 32'd1);
        check("init_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("init_addr", 32'(sram_addr), 32'd0);
        check("init_dq_out", 32'(sram_dq_out), 32'd0);
        check("init_rdata", 32'({disp_rdata, host_rdata}), 32'd0);
        check("init_rvalid", 32'({disp_rvalid, host_rvalid}), 32'd0);
        check("init_ready", 32'(host_ready), 32'd1);

        // Display burst: pulses follow two cycles after each request, back to back.
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            step(i < 4, 20'h00010 + 20'(i), 0, 0, '0, '0);
            pat[i] = disp_rvalid;
        end
        check("disp_burst_pattern", 32'(pat), 32'h1E);

        // Host write then read of the same address.
        step(0, '0, 1, 1, 20'h12345, 16'hBEEF);
        step(0, '0, 1, 0, 20'h12345, 16'h0000);
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            step(0, '0, 0, 0, '0, '0);
            if (host_rvalid) begin
                got = 1;
                check("wr_rd_data", 32'(host_rdata), 32'hBEEF);
            end
        end
        check("wr_rd_seen", 32'(got), 32'd1);
        idle(4);

        // Display priority over two queued writes.
        cnt = 0;
        step(1, 20'h00200, 1, 1, 20'h00100, 16'h1111);
        cnt += int'(!sram_we_n);
        step(1, 20'h00201, 1, 1, 20'h00101, 16'h2222);
        cnt += int'(!sram_we_n);
        for (int i = 0; i < 10; i++) begin
            step(1, 20'h00300 + 20'(i), 0, 0, '0, '0);
            cnt += int'(!sram_we_n);
        end
        check("prio_no_hwr", 32'(cnt), 32'd0);
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            step(0, '0, 0, 0, '0, '0);
            cnt += int'(!sram_we_n);
        end
        check("prio_hwr_after", 32'(cnt), 32'd2);
        step(0, '0, 1, 0, 20'h00101, '0);
        idle(4);

        // FIFO full: 5th command waits for the first pop.
        for (int i = 0; i < 4; i++) begin
            step(1, 20'h00400 + 20'(i), 1, 1, 20'h00200 + 20'(i), 16'hA000 + 16'(i));
            if (i == 2) check("full_ready_3", 32'(host_ready), 32'd1);
        end
        check("full_ready_4", 32'(host_ready), 32'd0);
        step(1, 20'h00404, 1, 1, 20'h00204, 16'h5555);
        check("full_held", 32'(host_ready), 32'd0);
        step(0, '0, 1, 1, 20'h00204, 16'h5555);
        check("full_after_pop", 32'(host_ready), 32'd1);
        step(0, '0, 1, 1, 20'h00204, 16'h5555);
        step(0, '0, 1, 0, 20'h00204, '0);
        idle(8);

        // Reset during a host write drops it and the queued read.
        step(0, '0, 1, 1, 20'h00300, 16'hCAFE);
        step(0, '0, 1, 0, 20'h00300, '0);
        check("pre_rst_hwr", 32'(sram_we_n), 32'd0);
        do_reset();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, '0, 0, 0, '0, '0);
            cnt += int'(host_rvalid);
        end
        check("rst_no_rvalid", 32'(cnt), 32'd0);
        step(0, '0, 1, 0, 20'h00300, '0);
        idle(4);

`ifdef SRAM_ARB_BLANK_WRITE_EN
        hc = 11'd100;
        vc = 10'd50;
        step(0, '0, 1, 1, 20'h00400, 16'h7777);
        step(0, '0, 0, 0, '0, '0);
        check("blank_idle_we", 32'(sram_we_n), 32'd1);
        check("blank_idle_oe", 32'(sram_oe_n), 32'd1);
        hc = 11'd800;
        step(0, '0, 0, 0, '0, '0);
        check("blank_issue", 32'(sram_we_n), 32'd0);
        idle(4);
`endif

        for (int i = 0; i < 3000; i++) begin
            bit dr;
            bit hv;
            bit hw;
            dr = ($urandom_range(0, 2) == 0);
            hv = ($urandom_range(0, 1) == 1);
            hw = ($urandom_range(0, 1) == 1);
            hc = 11'($urandom_range(0, 1055));
            vc = 10'($urandom_range(0, 627));
            if ($urandom_range(0, 999) == 0) do_reset();
            step(dr, 20'($urandom_range(0, 31)), hv, hw, 20'($urandom_range(0, 15)), 16'($urandom));
        end
        hc = 11'd800;
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
